// File: rtl/cpu_seq_ctrl.sv
// Instruction-cycle sequencer for the 8-bit training CPU: fetches two IR bytes, then runs 3 EXEC cycles.
// Optional single-step control is enabled with `define CPU_SEQ_SINGLE_STEP_EN.
module cpu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  output logic       ir_ena,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       addr_sel,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_HI = 3'd1,
    S_FETCH_LO = 3'd2,
    S_DECODE   = 3'd3,
    S_EXEC1    = 3'd4,
    S_EXEC2    = 3'd5,
    S_EXEC3    = 3'd6,
    S_HALTED   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } op_t;

  state_t r_state;
  state_t w_next;
  op_t    w_op;
  logic   w_alu;
  logic   w_go_idle;
  logic   w_go_exec3;

  assign w_op  = op_t'(opcode);
  assign w_alu = (w_op == OP_ADD) || (w_op == OP_AND) ||
                 (w_op == OP_XOR) || (w_op == OP_LDA);

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic r_step_q;
  logic w_step_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_step_q <= 1'b0;
    else      r_step_q <= step;
  end

  assign w_step_rise = step & ~r_step_q;
  assign w_go_idle   = run & (~step_mode | w_step_rise);
  assign w_go_exec3  = run & ~step_mode;
`else
  assign w_go_idle   = run;
  assign w_go_exec3  = run;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_go_idle ? S_FETCH_HI : S_IDLE;
      S_FETCH_HI: w_next = S_FETCH_LO;
      S_FETCH_LO: w_next = S_DECODE;
      S_DECODE:   w_next = (w_op == OP_HLT) ? S_HALTED : S_EXEC1;
      S_EXEC1:    w_next = S_EXEC2;
      S_EXEC2:    w_next = S_EXEC3;
      S_EXEC3:    w_next = w_go_exec3 ? S_FETCH_HI : S_IDLE;
      S_HALTED:   w_next = S_HALTED;
      default:    w_next = S_IDLE;
    endcase
  end

  // Moore outputs per state, qualified by opcode and (for SKZ) the zero flag.
  always_comb begin
    ir_ena      = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    addr_sel    = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH_HI, S_FETCH_LO: begin
        ir_ena = 1'b1;
        rd     = 1'b1;
        inc_pc = 1'b1;
      end
      S_EXEC1: begin
        if (w_alu) begin
          addr_sel = 1'b1;
          rd       = 1'b1;
        end else if (w_op == OP_STO) begin
          addr_sel    = 1'b1;
          datactl_ena = 1'b1;
        end else if (w_op == OP_JMP) begin
          load_pc = 1'b1;
        end
      end
      S_EXEC2: begin
        if (w_alu) begin
          addr_sel = 1'b1;
          rd       = 1'b1;
          load_acc = 1'b1;
        end else if (w_op == OP_STO) begin
          addr_sel    = 1'b1;
          datactl_ena = 1'b1;
          wr          = 1'b1;
        end else if (w_op == OP_SKZ && zero) begin
          inc_pc = 1'b1;
        end
      end
      S_EXEC3: begin
        if (w_op == OP_STO) begin
          addr_sel    = 1'b1;
          datactl_ena = 1'b1;
        end else if (w_op == OP_SKZ && zero) begin
          inc_pc = 1'b1;
        end
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed, table-driven bench for cpu_seq_ctrl (default build) plus hand sequences for
// halt hold, SKZ strobe totals and asynchronous reset in the middle of STO.
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [2:0] opcode;
  logic       zero;
  logic       ir_ena, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, addr_sel, halted;
  logic [2:0] state;

  cpu_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .opcode      (opcode),
    .zero        (zero),
    .ir_ena      (ir_ena),
    .rd          (rd),
    .wr          (wr),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .addr_sel    (addr_sel),
    .halted      (halted),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Output bundle order: ir_ena rd wr inc_pc load_pc load_acc datactl_ena addr_sel halted
  logic [8:0] outs;
  assign outs = {ir_ena, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, addr_sel, halted};

  localparam logic [8:0] O_NONE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_FETCH = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] O_ALU1  = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] O_ALU2  = 9'b0_1_0_0_0_1_0_1_0;
  localparam logic [8:0] O_STO1  = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] O_STO2  = 9'b0_0_1_0_0_0_1_1_0;
  localparam logic [8:0] O_SKZ   = 9'b0_0_0_1_0_0_0_0_0;
  localparam logic [8:0] O_JMP   = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] O_HALT  = 9'b0_0_0_0_0_0_0_0_1;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, STO = 3'b110, JMP = 3'b111;

  typedef struct {
    logic       rst_n;
    logic       run;
    logic [2:0] op;
    logic       zero;
    logic [2:0] exp_state;
    logic [8:0] exp_outs;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  function automatic vec_t mk(logic r, logic rn, logic [2:0] op, logic z,
                              logic [2:0] st, logic [8:0] o);
    vec_t v;
    v.rst_n = r; v.run = rn; v.op = op; v.zero = z; v.exp_state = st; v.exp_outs = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int unsigned cnt_inc;
    int unsigned cnt_ir;
    bit found;

    rst = 1'b0; run = 1'b1; opcode = ADD; zero = 1'b0;

    // Reset held 3 cycles with run=1, then ADD, STO, SKZ taken, SKZ not taken, JMP w/ run drop.
    tbl.push_back(mk(0, 1, ADD, 0, 3'd0, O_NONE));
    tbl.push_back(mk(0, 1, ADD, 0, 3'd0, O_NONE));
    tbl.push_back(mk(0, 1, ADD, 0, 3'd0, O_NONE));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd4, O_ALU1));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd5, O_ALU2));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd6, O_NONE));
    tbl.push_back(mk(1, 1, STO, 0, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, STO, 0, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, STO, 0, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, STO, 0, 3'd4, O_STO1));
    tbl.push_back(mk(1, 1, STO, 0, 3'd5, O_STO2));
    tbl.push_back(mk(1, 1, STO, 0, 3'd6, O_STO1));
    tbl.push_back(mk(1, 1, SKZ, 1, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, SKZ, 1, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, SKZ, 1, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, SKZ, 1, 3'd4, O_NONE));
    tbl.push_back(mk(1, 1, SKZ, 1, 3'd5, O_SKZ));
    tbl.push_back(mk(1, 1, SKZ, 1, 3'd6, O_SKZ));
    tbl.push_back(mk(1, 1, SKZ, 0, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, SKZ, 0, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, SKZ, 0, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, SKZ, 0, 3'd4, O_NONE));
    tbl.push_back(mk(1, 1, SKZ, 0, 3'd5, O_NONE));
    tbl.push_back(mk(1, 1, SKZ, 0, 3'd6, O_NONE));
    tbl.push_back(mk(1, 1, JMP, 0, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, JMP, 0, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, JMP, 0, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, JMP, 0, 3'd4, O_JMP));
    tbl.push_back(mk(1, 1, JMP, 0, 3'd5, O_NONE));
    tbl.push_back(mk(1, 0, JMP, 0, 3'd6, O_NONE));
    tbl.push_back(mk(1, 0, JMP, 0, 3'd0, O_NONE));
    tbl.push_back(mk(1, 0, JMP, 0, 3'd0, O_NONE));
    // Restart; drop run while in EXEC1 -- the instruction still completes.
    tbl.push_back(mk(1, 1, ADD, 0, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, ADD, 0, 3'd4, O_ALU1));
    tbl.push_back(mk(1, 0, ADD, 0, 3'd5, O_ALU2));
    tbl.push_back(mk(1, 0, ADD, 0, 3'd6, O_NONE));
    tbl.push_back(mk(1, 0, ADD, 0, 3'd0, O_NONE));
    // HLT: DECODE goes straight to HALTED.
    tbl.push_back(mk(1, 1, HLT, 0, 3'd1, O_FETCH));
    tbl.push_back(mk(1, 1, HLT, 0, 3'd2, O_FETCH));
    tbl.push_back(mk(1, 1, HLT, 0, 3'd3, O_NONE));
    tbl.push_back(mk(1, 1, HLT, 0, 3'd7, O_HALT));

    foreach (tbl[i]) begin
      rst = tbl[i].rst_n; run = tbl[i].run; opcode = tbl[i].op; zero = tbl[i].zero;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {state, outs}, {tbl[i].exp_state, tbl[i].exp_outs});
    end

    // HALTED holds for 20 cycles regardless of run.
    for (int k = 0; k < 20; k++) begin
      run = k[0];
      @(posedge clk); #1;
      chk($sformatf("halt_hold%0d", k), {state, outs}, {3'd7, O_HALT});
    end

    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b0;
    #1 chk("halt_async_rst", {state, outs}, {3'd0, O_NONE});

    // SKZ strobe totals over one instruction (states 1..6).
    @(negedge clk);
    run = 1'b1; opcode = SKZ; zero = 1'b1; rst = 1'b1;
    cnt_inc = 0; cnt_ir = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      cnt_inc += inc_pc; cnt_ir += ir_ena;
    end
    chk("skz_taken_inc_pc", 12'(cnt_inc), 12'd4);
    chk("skz_taken_ir_ena", 12'(cnt_ir), 12'd2);
    zero = 1'b0; cnt_inc = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      cnt_inc += inc_pc;
    end
    chk("skz_not_taken_inc_pc", 12'(cnt_inc), 12'd2);

    // STO reset mid-write: wr must fall with rst, no clock needed.
    opcode = STO; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (state == 3'd5) found = 1'b1;
    end
    chk("sto_reach_exec2", {11'd0, found}, 12'd1);
    chk("sto_wr_before_rst", {state, outs}, {3'd5, O_STO2});
    #2 rst = 1'b0;
    #1 chk("sto_mid_rst", {state, outs}, {3'd0, O_NONE});
    @(posedge clk); #1;
    chk("sto_rst_held", {state, outs}, {3'd0, O_NONE});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
